// File: rtl/sprite_color_stage.sv
// sprite_color_stage: resolves selector hits into registered DAC colour via sync sprite memory read,
// background colour and blanking, with a saturating per-frame opaque pixel counter.
module sprite_color_stage #(
  parameter int ELEMENT = 5,
  parameter int ADDR_W = 10,
  parameter int COLOR_W = 9,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 9'h1C7,
  parameter logic [COLOR_W-1:0] BG_RESET = 9'h000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ready,
  input  logic [ELEMENT-1:0]        element,
  input  logic [ADDR_W-1:0]         address,
  input  logic                      video_on,
  input  logic                      frame_start,
  input  logic                      bg_we,
  input  logic [COLOR_W-1:0]        bg_data,
  output logic                      mem_rd,
  output logic [ELEMENT+ADDR_W-1:0] mem_addr,
  input  logic [COLOR_W-1:0]        mem_data,
  output logic [COLOR_W-1:0]        rgb,
  output logic [15:0]               sprite_count
);
  logic hit1, von1, hit2, von2, opaque;
  logic [COLOR_W-1:0] bg_color;
  // hit2 gates first so undriven memory data never reaches rgb
  assign opaque = von2 && hit2 && (mem_data != TRANSPARENT);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_rd <= 1'b0;
      mem_addr <= '0;
      hit1 <= 1'b0;
      von1 <= 1'b0;
      hit2 <= 1'b0;
      von2 <= 1'b0;
      rgb <= '0;
      bg_color <= BG_RESET;
      sprite_count <= '0;
    end else begin
      mem_rd <= ready;
      if (ready) mem_addr <= {element, address};
      hit1 <= ready;
      von1 <= video_on;
      hit2 <= hit1;
      von2 <= von1;
      rgb <= !von2 ? '0 : opaque ? mem_data : bg_color;
      if (bg_we) bg_color <= bg_data;
      sprite_count <= frame_start ? 16'd0 :
                      (opaque && sprite_count != 16'hFFFF) ? sprite_count + 16'd1 : sprite_count;
    end
  end
endmodule

// File: tb/tb_sprite_color_stage.sv
// tb_sprite_color_stage: directed tests with a behavioural sync sprite memory.
module tb_sprite_color_stage;
  logic clk = 1'b0, reset_n = 1'b0, ready = 1'b0, video_on = 1'b0;
  logic frame_start = 1'b0, bg_we = 1'b0, mem_rd;
  logic [4:0] element = '0;
  logic [9:0] address = '0;
  logic [8:0] bg_data = '0, mem_data, rgb;
  logic [14:0] mem_addr;
  logic [15:0] sprite_count;
  int total = 0, bad = 0;

  sprite_color_stage dut (
    .clk(clk), .reset_n(reset_n), .ready(ready), .element(element), .address(address),
    .video_on(video_on), .frame_start(frame_start), .bg_we(bg_we), .bg_data(bg_data),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .rgb(rgb),
    .sprite_count(sprite_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] rom(input logic [14:0] a);
    case (a)
      15'h1015: rom = 9'h0A5;
      15'h0803: rom = 9'h1C7;
      15'h0400: rom = 9'h011;
      15'h0800: rom = 9'h022;
      15'h7FFF: rom = 9'h133;
      default:  rom = 9'h000;
    endcase
  endfunction

  // data is undefined whenever no read was issued
  always @(posedge clk) mem_data <= mem_rd ? rom(mem_addr) : 9'bx;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    step(2);
    chk("reset_rgb", {7'd0, rgb}, 16'h0);
    chk("reset_mem_rd", {15'd0, mem_rd}, 16'h0);
    chk("reset_mem_addr", {1'b0, mem_addr}, 16'h0);
    chk("reset_count", sprite_count, 16'h0);
    reset_n = 1'b1;
    video_on = 1'b1;
    step(3);
    chk("reset_bg", {7'd0, rgb}, 16'h000);
    ready = 1'b1; element = 5'd4; address = 10'h015;
    step(4);
    chk("midframe_pre", {7'd0, rgb}, 16'h0A5);
    @(negedge clk) reset_n = 1'b0;
    #1;
    chk("midframe_rgb", {7'd0, rgb}, 16'h0);
    chk("midframe_mem_rd", {15'd0, mem_rd}, 16'h0);
    chk("midframe_mem_addr", {1'b0, mem_addr}, 16'h0);
    chk("midframe_count", sprite_count, 16'h0);
    @(negedge clk) reset_n = 1'b1;
    step(1);
    chk("release_mem_rd", {15'd0, mem_rd}, 16'h1);
    chk("release_rgb1", {7'd0, rgb}, 16'h0);
    step(1);
    chk("release_rgb2", {7'd0, rgb}, 16'h0);
    step(1);
    chk("release_rgb3", {7'd0, rgb}, 16'h0A5);
    ready = 1'b0;
    step(3);
  endtask

  task automatic test_opaque;
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    chk("clear_count", sprite_count, 16'h0);
    ready = 1'b1; element = 5'd4; address = 10'h015;
    step(1);
    ready = 1'b0;
    chk("opaque_mem_rd", {15'd0, mem_rd}, 16'h1);
    chk("opaque_mem_addr", {1'b0, mem_addr}, 16'h1015);
    step(1);
    chk("opaque_rgb_early", {7'd0, rgb}, 16'h0);
    step(1);
    chk("opaque_rgb", {7'd0, rgb}, 16'h0A5);
    chk("opaque_count", sprite_count, 16'h1);
    step(1);
    chk("after_hit_bg", {7'd0, rgb}, 16'h0);
  endtask

  task automatic test_transparent;
    bg_we = 1'b1; bg_data = 9'h038;
    step(1);
    bg_we = 1'b0;
    ready = 1'b1; element = 5'd2; address = 10'h003;
    step(1);
    ready = 1'b0;
    step(2);
    chk("transparent_rgb", {7'd0, rgb}, 16'h038);
    chk("transparent_count", sprite_count, 16'h1);
  endtask

  task automatic test_blanking;
    ready = 1'b1; video_on = 1'b0; element = 5'd4; address = 10'h015;
    step(1);
    ready = 1'b0; video_on = 1'b1;
    step(2);
    chk("blank_rgb", {7'd0, rgb}, 16'h0);
    chk("blank_count", sprite_count, 16'h1);
    step(1);
    chk("unblank_bg", {7'd0, rgb}, 16'h038);
  endtask

  task automatic test_bg_race;
    step(2);
    bg_we = 1'b1; bg_data = 9'h1FF;
    step(1);
    bg_we = 1'b0;
    chk("race_old_bg", {7'd0, rgb}, 16'h038);
    step(1);
    chk("race_new_bg", {7'd0, rgb}, 16'h1FF);
  endtask

  task automatic test_back_to_back;
    ready = 1'b1; element = 5'd1; address = 10'h000;
    step(1);
    chk("b2b_addr_a", {1'b0, mem_addr}, 16'h0400);
    element = 5'd2;
    step(1);
    chk("b2b_addr_b", {1'b0, mem_addr}, 16'h0800);
    element = 5'd31; address = 10'h3FF;
    step(1);
    chk("b2b_addr_max", {1'b0, mem_addr}, 16'h7FFF);
    chk("b2b_rgb_a", {7'd0, rgb}, 16'h011);
    ready = 1'b0;
    step(1);
    chk("b2b_hold_addr", {1'b0, mem_addr}, 16'h7FFF);
    chk("b2b_rgb_b", {7'd0, rgb}, 16'h022);
    step(1);
    chk("b2b_rgb_max", {7'd0, rgb}, 16'h133);
    chk("b2b_count", sprite_count, 16'h4);
    step(1);
    chk("b2b_mem_rd_idle", {15'd0, mem_rd}, 16'h0);
  endtask

  task automatic test_counter;
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    ready = 1'b1; element = 5'd4; address = 10'h015;
    step(70000);
    chk("sat_count", sprite_count, 16'hFFFF);
    step(5);
    chk("sat_hold", sprite_count, 16'hFFFF);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    chk("clear_wins", sprite_count, 16'h0);
    step(1);
    chk("count_restart", sprite_count, 16'h1);
    ready = 1'b0;
    step(3);
  endtask

  initial begin
    test_reset;
    test_opaque;
    test_transparent;
    test_blanking;
    test_bg_race;
    test_back_to_back;
    test_counter;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
